// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared stage indices, hold/flush patterns and FSM encoding for the
// pipeline stall/flush controller.
package pipe_hold_ctrl_pkg;

  localparam int STG_PC     = 0;
  localparam int STG_IF_ID  = 1;
  localparam int STG_ID_EX  = 2;
  localparam int STG_EX_MEM = 3;
  localparam int STG_MEM_WB = 4;
  localparam int NUM_STG    = 5;

  localparam logic [NUM_STG-1:0] HOLD_ALL  = 5'b11111;
  localparam logic [NUM_STG-1:0] HOLD_NONE = 5'b00000;
  localparam logic [NUM_STG-1:0] HOLD_LDU  = 5'b00011;
  localparam logic [NUM_STG-1:0] HOLD_DIV  = 5'b00111;

  // Bubble patterns: jump squashes IF/ID and ID/EX, divide bubbles EX/MEM,
  // load-use and divide abort bubble ID/EX.
  localparam logic [NUM_STG-1:0] FLUSH_NONE = 5'b00000;
  localparam logic [NUM_STG-1:0] FLUSH_JMP  = 5'b00110;
  localparam logic [NUM_STG-1:0] FLUSH_DIV  = 5'b01000;
  localparam logic [NUM_STG-1:0] FLUSH_IDEX = 5'b00100;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_WAIT = 2'd1,
    JMP_PEND = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_hold_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                    r_cnt <= '0;
    else if (i_clr)                  r_cnt <= '0;
    else if (i_inc && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Central stall/flush controller: sequences bus wait, divide, jump redirect
// and load-use hazards into per-stage hold/flush controls.
module pipe_hold_ctrl
  import pipe_hold_ctrl_pkg::*;
#(
  parameter int DIV_TIMEOUT = 64,
  parameter int CNT_W       = 32,
  parameter int ADDR_W      = 32
) (
  input  logic              clk_100MHz,
  input  logic              arst_n,
  input  logic              bus_wait_i,
  input  logic              div_start_i,
  input  logic              div_done_i,
  input  logic              jump_ena_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              ld_use_i,
  input  logic              cnt_clr_i,
  output logic [4:0]        hold_o,
  output logic [4:0]        flush_o,
  output logic              jump_ena_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              div_err_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int              WD_W    = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(DIV_TIMEOUT - 1);

  state_e              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_jaddr;
  logic [WD_W-1:0]     r_wdog;
  logic                r_div_err;

  logic [4:0]          w_hold, w_flush;
  logic                w_jena;
  logic [ADDR_W-1:0]   w_jaddr;
  logic                w_latch, w_wd_clr, w_wd_inc, w_err_set;

  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      r_state   <= RUN;
      r_jaddr   <= '0;
      r_wdog    <= '0;
      r_div_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch)        r_jaddr <= jump_addr_i;
      if (w_wd_clr)       r_wdog  <= '0;
      else if (w_wd_inc)  r_wdog  <= r_wdog + 1'b1;
      if (w_err_set)      r_div_err <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold      = HOLD_NONE;
    w_flush     = FLUSH_NONE;
    w_jena      = 1'b0;
    w_jaddr     = '0;
    w_latch     = 1'b0;
    w_wd_clr    = 1'b0;
    w_wd_inc    = 1'b0;
    w_err_set   = 1'b0;
    unique case (r_state)
      RUN: begin
        if (bus_wait_i) begin
          w_hold = HOLD_ALL;
          // A jump that collides with a bus wait is replayed once the wait drops.
          if (jump_ena_i) begin
            w_latch     = 1'b1;
            w_state_nxt = JMP_PEND;
          end
        end else if (jump_ena_i) begin
          w_jena  = 1'b1;
          w_jaddr = jump_addr_i;
          w_flush = FLUSH_JMP;
        end else if (div_start_i) begin
          w_hold      = HOLD_DIV;
          w_flush     = FLUSH_DIV;
          w_wd_clr    = 1'b1;
          w_state_nxt = DIV_WAIT;
        end else if (ld_use_i) begin
          w_hold  = HOLD_LDU;
          w_flush = FLUSH_IDEX;
        end
      end
      DIV_WAIT: begin
        if (bus_wait_i) begin
          w_hold = HOLD_ALL;
        end else if (div_done_i) begin
          w_state_nxt = RUN;
        end else if (r_wdog == WD_LAST) begin
          w_err_set   = 1'b1;
          w_flush     = FLUSH_IDEX;
          w_state_nxt = RUN;
        end else begin
          w_hold   = HOLD_DIV;
          w_flush  = FLUSH_DIV;
          w_wd_inc = 1'b1;
        end
      end
      JMP_PEND: begin
        if (bus_wait_i) begin
          w_hold = HOLD_ALL;
        end else begin
          w_jena      = 1'b1;
          w_jaddr     = r_jaddr;
          w_flush     = FLUSH_JMP;
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // Combinational controls must read as idle for the whole reset window.
  assign hold_o      = arst_n ? w_hold  : HOLD_NONE;
  assign flush_o     = arst_n ? w_flush : FLUSH_NONE;
  assign jump_ena_o  = arst_n & w_jena;
  assign jump_addr_o = arst_n ? w_jaddr : '0;
  assign div_err_o   = r_div_err;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .i_clk   (clk_100MHz),
    .i_rst_n (arst_n),
    .i_inc   (hold_o[STG_PC]),
    .i_clr   (cnt_clr_i),
    .o_cnt   (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Scoreboard bench for pipe_hold_ctrl: per-cycle expected controls are queued
// as stimulus is driven and compared by a negedge monitor.
module tb_pipe_hold_ctrl;

  localparam int DIV_TIMEOUT = 8;
  localparam int CNT_W       = 3;
  localparam int ADDR_W      = 32;

  logic              clk = 1'b0;
  logic              arst_n;
  logic              bus_wait_i, div_start_i, div_done_i, jump_ena_i, ld_use_i, cnt_clr_i;
  logic [ADDR_W-1:0] jump_addr_i;
  logic [4:0]        hold_o, flush_o;
  logic              jump_ena_o, div_err_o;
  logic [ADDR_W-1:0] jump_addr_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  typedef struct {
    string       tag;
    logic [42:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  pipe_hold_ctrl #(
    .DIV_TIMEOUT (DIV_TIMEOUT),
    .CNT_W       (CNT_W),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk_100MHz  (clk),
    .arst_n      (arst_n),
    .bus_wait_i  (bus_wait_i),
    .div_start_i (div_start_i),
    .div_done_i  (div_done_i),
    .jump_ena_i  (jump_ena_i),
    .jump_addr_i (jump_addr_i),
    .ld_use_i    (ld_use_i),
    .cnt_clr_i   (cnt_clr_i),
    .hold_o      (hold_o),
    .flush_o     (flush_o),
    .jump_ena_o  (jump_ena_o),
    .jump_addr_o (jump_addr_o),
    .div_err_o   (div_err_o),
    .stall_cnt_o (stall_cnt_o)
  );

  wire [42:0] w_obs = {hold_o, flush_o, jump_ena_o, jump_addr_o};

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (w_obs !== e.v) begin
        fails++;
        $display("FAIL %s: hold/flush/jena/jaddr got %b_%b_%b_%h expected %b_%b_%b_%h",
                 e.tag, w_obs[42:38], w_obs[37:33], w_obs[32], w_obs[31:0],
                 e.v[42:38], e.v[37:33], e.v[32], e.v[31:0]);
      end
    end
  end

  // One pipeline cycle: drive inputs just after the edge and queue the
  // controls the same cycle must show.
  task automatic drv(input string tag, input logic bw, ds, dd, je, lu, clr,
                     input logic [31:0] ja, input logic [4:0] eh, ef,
                     input logic ej, input logic [31:0] eja);
    exp_t e;
    @(posedge clk); #1;
    bus_wait_i = bw; div_start_i = ds; div_done_i = dd;
    jump_ena_i = je; ld_use_i = lu;   cnt_clr_i = clr; jump_addr_i = ja;
    e.tag = tag;
    e.v   = {eh, ef, ej, eja};
    sb.push_back(e);
  endtask

  task automatic idle(input string tag, input logic clr);
    drv(tag, 0,0,0,0,0,clr, 32'h0, 5'b00000, 5'b00000, 1'b0, 32'h0);
  endtask

  task automatic test_reset;
    arst_n = 1'b0;
    bus_wait_i = 1; div_start_i = 1; div_done_i = 0; jump_ena_i = 1;
    ld_use_i = 1; cnt_clr_i = 0; jump_addr_i = 32'hABCD_0000;
    #2;
    checks++;
    if (w_obs !== 43'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0", w_obs);
    end
    checks++;
    if ({div_err_o, stall_cnt_o} !== 4'h0) begin
      fails++;
      $display("FAIL reset_regs: err/cnt got %b/%0d expected 0/0", div_err_o, stall_cnt_o);
    end
    bus_wait_i = 0; div_start_i = 0; jump_ena_i = 0; ld_use_i = 0; jump_addr_i = '0;
    @(negedge clk);
    arst_n = 1'b1;
    idle("reset_idle", 0);
  endtask

  task automatic test_load_use;
    drv("ldu", 0,0,0,0,1,0, 32'h0, 5'b00011, 5'b00100, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (stall_cnt_o !== 3'd0) begin
      fails++;
      $display("FAIL ldu_cnt_before: got %0d expected 0", stall_cnt_o);
    end
    idle("ldu_after", 0);
    @(negedge clk);
    checks++;
    if (stall_cnt_o !== 3'd1) begin
      fails++;
      $display("FAIL ldu_cnt_after: got %0d expected 1", stall_cnt_o);
    end
  endtask

  task automatic test_divide;
    idle("div_clr", 1);
    drv("div_start", 0,1,0,0,0,0, 32'h0, 5'b00111, 5'b01000, 1'b0, 32'h0);
    for (int i = 1; i <= 4; i++)
      drv("div_wait", 0,0,0,0,0,0, 32'h0, 5'b00111, 5'b01000, 1'b0, 32'h0);
    drv("div_done", 0,0,1,0,0,0, 32'h0, 5'b00000, 5'b00000, 1'b0, 32'h0);
    drv("div_run_ldu", 0,0,0,0,1,0, 32'h0, 5'b00011, 5'b00100, 1'b0, 32'h0);
    idle("div_idle", 0);
    @(negedge clk);
    checks++;
    if (stall_cnt_o !== 3'd6) begin
      fails++;
      $display("FAIL div_cnt: got %0d expected 6", stall_cnt_o);
    end
  endtask

  task automatic test_jump_bus;
    idle("jb_clr", 1);
    drv("jb_wait0", 1,0,0,0,0,0, 32'h0,   5'b11111, 5'b00000, 1'b0, 32'h0);
    drv("jb_wait1", 1,0,0,1,0,0, 32'h100, 5'b11111, 5'b00000, 1'b0, 32'h0);
    drv("jb_wait2", 1,0,0,1,0,0, 32'h200, 5'b11111, 5'b00000, 1'b0, 32'h0);
    drv("jb_wait3", 1,0,0,0,0,0, 32'h0,   5'b11111, 5'b00000, 1'b0, 32'h0);
    drv("jb_replay", 0,0,0,0,0,0, 32'h0,  5'b00000, 5'b00110, 1'b1, 32'h100);
    @(negedge clk);
    checks++;
    if (stall_cnt_o !== 3'd4) begin
      fails++;
      $display("FAIL jb_cnt: got %0d expected 4", stall_cnt_o);
    end
    idle("jb_idle", 0);
  endtask

  task automatic test_watchdog;
    idle("wd_clr", 1);
    drv("wd_start", 0,1,0,0,0,0, 32'h0, 5'b00111, 5'b01000, 1'b0, 32'h0);
    for (int i = 1; i <= 7; i++)
      drv("wd_wait", 0,0,0,1,1,0, 32'h44, 5'b00111, 5'b01000, 1'b0, 32'h0);
    drv("wd_abort", 0,0,0,0,0,0, 32'h0, 5'b00000, 5'b00100, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (div_err_o !== 1'b0) begin
      fails++;
      $display("FAIL wd_err_early: got %b expected 0", div_err_o);
    end
    checks++;
    if (stall_cnt_o !== 3'd7) begin
      fails++;
      $display("FAIL wd_cnt_sat: got %0d expected 7", stall_cnt_o);
    end
    drv("wd_run_ldu", 0,0,0,0,1,0, 32'h0, 5'b00011, 5'b00100, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (div_err_o !== 1'b1) begin
      fails++;
      $display("FAIL wd_err_set: got %b expected 1", div_err_o);
    end
    for (int i = 0; i < 3; i++) idle("wd_idle", 0);
    @(negedge clk);
    checks++;
    if (div_err_o !== 1'b1) begin
      fails++;
      $display("FAIL wd_err_sticky: got %b expected 1", div_err_o);
    end
    // Bus wait freezes the watchdog: 6 + 3 frozen + 2 cycles to reach the abort.
    drv("wdf_start", 0,1,0,0,0,0, 32'h0, 5'b00111, 5'b01000, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++)
      drv("wdf_wait", 0,0,0,0,0,0, 32'h0, 5'b00111, 5'b01000, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++)
      drv("wdf_bus", 1,0,0,0,0,0, 32'h0, 5'b11111, 5'b00000, 1'b0, 32'h0);
    drv("wdf_last", 0,0,0,0,0,0, 32'h0, 5'b00111, 5'b01000, 1'b0, 32'h0);
    drv("wdf_abort", 0,0,0,0,0,0, 32'h0, 5'b00000, 5'b00100, 1'b0, 32'h0);
    idle("wdf_idle", 0);
  endtask

  task automatic test_simultaneous;
    drv("sim_jump", 0,1,0,1,1,0, 32'hDEAD_BEEF, 5'b00000, 5'b00110, 1'b1, 32'hDEAD_BEEF);
    idle("sim_no_div", 0);
    drv("sim_div", 0,1,0,0,0,0, 32'h0, 5'b00111, 5'b01000, 1'b0, 32'h0);
    drv("sim_bw_done", 1,0,1,0,0,0, 32'h0, 5'b11111, 5'b00000, 1'b0, 32'h0);
    drv("sim_bw", 1,0,0,0,0,0, 32'h0, 5'b11111, 5'b00000, 1'b0, 32'h0);
    drv("sim_div_ign", 0,1,0,1,1,0, 32'h55, 5'b00111, 5'b01000, 1'b0, 32'h0);
    drv("sim_done", 0,0,1,0,0,0, 32'h0, 5'b00000, 5'b00000, 1'b0, 32'h0);
    drv("sim_run_ldu", 0,0,0,0,1,0, 32'h0, 5'b00011, 5'b00100, 1'b0, 32'h0);
  endtask

  task automatic test_reset_mid_and_sat;
    idle("rm_clr", 1);
    drv("rm_div", 0,1,0,0,0,0, 32'h0, 5'b00111, 5'b01000, 1'b0, 32'h0);
    drv("rm_wait", 0,0,0,0,0,0, 32'h0, 5'b00111, 5'b01000, 1'b0, 32'h0);
    @(posedge clk); #1;
    bus_wait_i = 1; arst_n = 1'b0;
    #1;
    checks++;
    if (w_obs !== 43'h0) begin
      fails++;
      $display("FAIL rm_outputs: got %h expected 0", w_obs);
    end
    checks++;
    if ({div_err_o, stall_cnt_o} !== 4'h0) begin
      fails++;
      $display("FAIL rm_regs: err/cnt got %b/%0d expected 0/0", div_err_o, stall_cnt_o);
    end
    @(negedge clk);
    bus_wait_i = 0; arst_n = 1'b1;
    drv("rm_run_ldu", 0,0,0,0,1,0, 32'h0, 5'b00011, 5'b00100, 1'b0, 32'h0);
    // Reset while a jump is pending must not replay it.
    drv("rp_pend", 1,0,0,1,0,0, 32'h300, 5'b11111, 5'b00000, 1'b0, 32'h0);
    @(posedge clk); #1;
    bus_wait_i = 0; jump_ena_i = 0; arst_n = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    idle("rp_no_replay", 0);
    for (int i = 0; i < 10; i++)
      drv("sat_bw", 1,0,0,0,0,0, 32'h0, 5'b11111, 5'b00000, 1'b0, 32'h0);
    drv("sat_clr", 1,0,0,0,0,1, 32'h0, 5'b11111, 5'b00000, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (stall_cnt_o !== 3'd7) begin
      fails++;
      $display("FAIL sat_cnt: got %0d expected 7", stall_cnt_o);
    end
    idle("sat_idle", 0);
    @(negedge clk);
    checks++;
    if (stall_cnt_o !== 3'd0) begin
      fails++;
      $display("FAIL sat_clr_prio: got %0d expected 0", stall_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_divide();
    test_jump_bus();
    test_watchdog();
    test_simultaneous();
    test_reset_mid_and_sat();
    idle("final", 0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d entries expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hold_ctrl.md
Name: pipe_hold_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. Drives per-stage hold and flush controls for pc, if_id, id_ex, ex_mem and mem_wb. Sequences four event classes: system/bus wait, multi-cycle divide, jump redirect and load-use hazard. Holds a jump that arrives during a system hold and replays it when the hold ends. Also keeps a divide watchdog and a stall-cycle counter.

Parameters:
DIV_TIMEOUT, 64, max cycles in DIV_WAIT before abort (>=2)
CNT_W, 32, stall counter width
ADDR_W, 32, jump address width

Ports:
clk_100MHz  in  1  system clock
arst_n  in  1  asynchronous active-low reset
bus_wait_i  in  1  system hold request (memory/bus not ready)
div_start_i  in  1  divide issued in EX this cycle
div_done_i  in  1  divider result valid this cycle
jump_ena_i  in  1  branch/jump taken in EX
jump_addr_i  in  ADDR_W  jump target
ld_use_i  in  1  load-use hazard detected in ID
cnt_clr_i  in  1  synchronous clear of stall counter
hold_o  out  5  hold per stage; bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb
flush_o  out  5  bubble insert per stage, same bit order
jump_ena_o  out  1  redirect pc
jump_addr_o  out  ADDR_W  redirect target
div_err_o  out  1  sticky: divide watchdog expired
stall_cnt_o  out  CNT_W  count of cycles with hold_o[0]=1

Behaviour:
- Reset (arst_n low, async): state=RUN, latched jump addr=0, watchdog=0, div_err_o=0, stall_cnt_o=0. hold_o, flush_o, jump_ena_o and jump_addr_o are forced to 0 while arst_n is low.
- hold_o, flush_o, jump_ena_o and jump_addr_o are combinational from state and inputs, so the response lands in the same cycle. State, latch, watchdog, error flag and counter are registered.
- FSM states:
  - RUN:
    - Priority is bus_wait_i > jump_ena_i > div_start_i > ld_use_i.
    - bus_wait_i: hold=11111, flush=00000. If jump_ena_i is also high, latch jump_addr_i and go to JMP_PEND.
    - jump_ena_i: jump_ena_o=1, jump_addr_o=jump_addr_i, hold=00000, flush=00110. ld_use_i and div_start_i are ignored because that instruction is squashed.
    - div_start_i: hold=00111, flush=01000, watchdog=0, go to DIV_WAIT.
    - ld_use_i: hold=00011, flush=00100.
    - Otherwise all outputs are 0.
  - DIV_WAIT:
    - bus_wait_i: hold=11111, flush=0, watchdog frozen.
    - Else if div_done_i: hold=0, flush=0, go to RUN. The result advances into ex_mem.
    - Else if watchdog==DIV_TIMEOUT-1: set div_err_o, hold=0, flush=00100 (drop the divide), go to RUN.
    - Else: hold=00111, flush=01000, watchdog+1.
    - jump_ena_i, ld_use_i and div_start_i are ignored, since EX is occupied by the divide.
    - div_done_i and bus_wait_i in the same cycle: the wait wins and the state holds. The divider keeps its result until the wait drops.
  - JMP_PEND:
    - While bus_wait_i: hold=11111, flush=0.
    - On the first cycle with bus_wait_i low: jump_ena_o=1, jump_addr_o=latched addr, hold=0, flush=00110, go to RUN.
    - New jump_ena_i while pending is ignored, because the pending jump flushes its source.
- Stall counter:
  - +1 on each cycle with hold_o[0]=1, saturating at 2^CNT_W-1.
  - cnt_clr_i has priority and sets it to 0, even in a stall cycle.
- div_err_o clears only on reset.
- Reset asserted mid-DIV_WAIT or mid-JMP_PEND discards all pending state.

Decomposition:
- Shared define file:
  - stage bit indices (STG_PC=0 … STG_MEM_WB=4)
  - HOLD_ALL=5'b11111 and HOLD_NONE
  - FSM state encodings (RUN=2'd0, DIV_WAIT=2'd1, JMP_PEND=2'd2)
- One sub-module, sat_counter (CNT_W, inc, clr, saturating), used for stall_cnt_o. The watchdog stays inline.

Test Plan:
1. Load-use in RUN: ld_use_i=1 for one cycle → hold=00011, flush=00100 that cycle; stall_cnt_o 0→1.
2. Divide: div_start_i at cycle 0, div_done_i at cycle 5 → hold=00111/flush=01000 for cycles 0–4, zero at cycle 5, state RUN at 6; stall_cnt_o=5.
3. Jump during bus wait: bus_wait_i high cycles 0–3, jump_ena_i=1 with addr 0x0000_0100 at cycle 1 → hold=11111 for cycles 0–3; at cycle 4 jump_ena_o=1, jump_addr_o=0x100, flush=00110.
4. Watchdog: DIV_TIMEOUT=8, div_start_i with no done → flush=00100 and div_err_o=1 on the 8th DIV_WAIT cycle, then RUN; div_err_o stays 1 until reset.
5. Simultaneous events: jump_ena_i+ld_use_i+div_start_i in RUN → jump only (flush=00110, no DIV_WAIT). In DIV_WAIT, bus_wait_i+div_done_i → hold=11111 and state unchanged.
6. Reset mid-DIV_WAIT plus counter saturation: arst_n low in DIV_WAIT → all outputs 0 immediately, state RUN after release. With CNT_W=3 and 10 stall cycles → stall_cnt_o=7; cnt_clr_i during a stall → 0.
